// File: rtl/sram_1rw_port_ctrl.sv
// Valid/ready front end for port 0 (1RW) of the sky130 1 KB OpenRAM macro.
// Registered pin drive, two-stage read tracking and a credit-guarded response FIFO.
module sram_1rw_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    logic                  rd_a;
    logic                  rd_b;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [SUM_W-1:0]      credits_used;
    logic                  accept;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Every read in the pipe or buffered owns a FIFO slot, so pushes never overflow.
    always_comb begin
        credits_used = SUM_W'(rd_a) + SUM_W'(rd_b) + SUM_W'(fifo_count);
    end

    assign req_ready = credits_used < SUM_W'(RSP_DEPTH);
    assign accept    = req_valid && req_ready;
    assign push      = rd_b;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (accept) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~req_we;
            sram_wmask0 <= req_we ? req_wmask : '0;
            sram_addr0  <= req_addr;
            sram_din0   <= req_wdata;
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
        end
    end

    // rd_b marks the edge where the macro's dout0 holds this read's word.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            rd_a <= 1'b0;
            rd_b <= 1'b0;
        end else begin
            rd_a <= accept && !req_we;
            rd_b <= rd_a;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_dout0;
        end
    end

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Bench for sram_1rw_port_ctrl: directed scenarios plus random traffic against a
// word-level memory/response-queue model, with a behavioural 1RW macro on the pins.
module tb_sram_1rw_port_ctrl;

    localparam int DEPTH = 4;

    logic        clk0 = 1'b0;
    logic        rstb0;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    sram_1rw_port_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk0(clk0), .rstb0(rstb0),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk0 = ~clk0;

    // Behavioural macro: pins latched on posedge, write/read on the following negedge.
    logic [31:0] smem [256];
    logic        m_csb;
    logic        m_web;
    logic [3:0]  m_wmask;
    logic [7:0]  m_addr;
    logic [31:0] m_din;

    always @(posedge clk0) begin
        m_csb   <= sram_csb0;
        m_web   <= sram_web0;
        m_wmask <= sram_wmask0;
        m_addr  <= sram_addr0;
        m_din   <= sram_din0;
    end

    always @(negedge clk0) begin
        if (m_csb === 1'b0 && m_web === 1'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (m_wmask[b]) smem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
            end
        end
        if (m_csb === 1'b0 && m_web === 1'b1) sram_dout0 <= smem[m_addr];
        else sram_dout0 <= $urandom;
    end

    // Reference model: memory image and expected read responses in order.
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];
    logic        exp_csb, exp_web;
    logic [3:0]  exp_wmask;
    logic [7:0]  exp_addr;
    logic [31:0] exp_din;
    logic [31:0] last_rsp;
    int n_cmp = 0, n_err = 0, cyc = 0;
    int pops = 0, n_acc = 0, first_pop = -1, last_pop = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] m,
                         input logic [7:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Called at a negedge with inputs set; ends at the next negedge after checking.
    task automatic tick();
        logic acc, pop;
        logic [31:0] head;
        acc = rstb0 && req_valid && req_ready;
        pop = rstb0 && rsp_valid && rsp_ready;
        if (!rstb0) begin
            exp_q.delete();
            exp_csb = 1'b1; exp_web = 1'b1; exp_wmask = '0;
            exp_addr = '0; exp_din = '0;
        end
        if (pop) begin
            chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                head = exp_q.pop_front();
                chk("rsp_data", rsp_rdata, head);
            end
            last_rsp = rsp_rdata;
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (acc) begin
            n_acc++;
            if (req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end
            end else begin
                exp_q.push_back(ref_mem[req_addr]);
            end
            exp_csb   = 1'b0;
            exp_web   = ~req_we;
            exp_wmask = req_we ? req_wmask : 4'h0;
            exp_addr  = req_addr;
            exp_din   = req_wdata;
        end else if (rstb0) begin
            exp_csb = 1'b1; exp_web = 1'b1; exp_wmask = '0;
        end
        cyc++;
        @(posedge clk0);
        @(negedge clk0);
        chk("csb0", 32'(sram_csb0), 32'(exp_csb));
        chk("web0", 32'(sram_web0), 32'(exp_web));
        chk("wmask0", 32'(sram_wmask0), 32'(exp_wmask));
        chk("addr0", 32'(sram_addr0), 32'(exp_addr));
        chk("din0", sram_din0, exp_din);
        chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
        chk("no_overflow", 32'(exp_q.size() <= DEPTH), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i]    = '0;
            ref_mem[i] = '0;
        end
        rstb0 = 1'b0;
        rsp_ready = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset
        repeat (3) tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rstb0 = 1'b1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Basic write then read, with latency
        rsp_ready = 1'b1;
        drive(1, 1, 4'hF, 8'h12, 32'hDEADBEEF);
        tick();
        drive(1, 0, 4'h0, 8'h12, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("lat_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_2", 32'(rsp_valid), 32'd1);
        chk("basic_data", rsp_rdata, 32'hDEADBEEF);
        tick();

        // Byte mask
        drive(1, 1, 4'hF, 8'd5, 32'h11223344);
        tick();
        drive(1, 1, 4'b0101, 8'd5, 32'hAABBCCDD);
        tick();
        drive(1, 0, 4'h0, 8'd5, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("bmask", last_rsp, 32'h11BB33DD);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 4'hF, 8'(i), 32'hA5A50000 + 32'(i));
            tick();
        end
        pops = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 4'h0, 8'(i), 32'h0);
            chk("stream_ready", 32'(req_ready), 32'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        repeat (6) tick();
        chk("stream_count", 32'(pops), 32'd8);
        chk("stream_span", 32'(last_pop - first_pop), 32'd7);
        chk("stream_last", last_rsp, 32'hA5A50007);

        // Backpressure
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 4'h0, 8'(i % 8), 32'h0);
            tick();
        end
        chk("bp_accepts", 32'(n_acc), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        drive(0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        pops = 0;
        repeat (8) tick();
        chk("bp_pops", 32'(pops), 32'd4);
        chk("bp_ready_high", 32'(req_ready), 32'd1);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream: one buffered, two in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 4'h0, 8'(i), 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rstb0 = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_csb", 32'(sram_csb0), 32'd1);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk0);
        repeat (2) tick();
        rstb0 = 1'b1;
        rsp_ready = 1'b1;
        pops = 0;
        repeat (5) tick();
        chk("no_stale", 32'(pops), 32'd0);
        drive(1, 0, 4'h0, 8'h12, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("fresh_read", last_rsp, 32'hDEADBEEF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom);
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        chk("final_valid", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
